// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master DataMem arbiter; bursts capped at MAX_BURST beats while the other master waits
module dmem_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] CNT_MAX = 8'(MAX_BURST - 1);

  state_t     state, state_nxt;
  logic       last_owner;
  logic [7:0] beat_cnt;
  logic       beat0, beat1, burst_done;

  assign m0_gnt     = (state == OWN0);
  assign m1_gnt     = (state == OWN1);
  assign beat0      = m0_gnt & m0_req;
  assign beat1      = m1_gnt & m1_req;
  assign burst_done = (beat_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        // last_owner=1 means m0 wins a tie
        if (m0_req && m1_req) state_nxt = last_owner ? OWN0 : OWN1;
        else if (m0_req)      state_nxt = OWN0;
        else if (m1_req)      state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_req)                   state_nxt = m1_req ? OWN1 : IDLE;
        else if (m1_req && burst_done) state_nxt = OWN1;
      end
      OWN1: begin
        if (!m1_req)                   state_nxt = m0_req ? OWN0 : IDLE;
        else if (m0_req && burst_done) state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase
    if (!reset && beat0) begin
      mem_rd    = ~m0_wr;
      mem_wr    = m0_wr;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (!reset && beat1) begin
      mem_rd    = ~m1_wr;
      mem_wr    = m1_wr;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= 1'b1;
      beat_cnt   <= 8'd0;
    end else if (state_nxt != state) begin
      beat_cnt <= 8'd0;
      if (state_nxt == OWN0)      last_owner <= 1'b0;
      else if (state_nxt == OWN1) last_owner <= 1'b1;
    end else if ((beat0 || beat1) && !burst_done) begin
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

  // Read return is tied to the beat, not the grant, so a handover cannot lose it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= beat0 & ~m0_wr;
      m1_rvalid <= beat1 & ~m1_wr;
      if (beat0 && !m0_wr) m0_rdata <= mem_rdata;
      if (beat1 && !m1_wr) m1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter against a behavioural arbitration model
module tb_dmem_arbiter;

  localparam int MB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.DW(32), .AW(32), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE0000 ^ 32'(i * 7919);
  endfunction

  // DataMem stand-in: 64 words, refilled while reset is high
  logic [31:0] tb_mem [64];
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 64; i++) tb_mem[i] <= pat(i);
    else if (mem_wr) tb_mem[mem_addr[7:2]] <= mem_wdata;
  end
  assign mem_rdata = tb_mem[mem_addr[7:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int due; logic [31:0] data;} exp_t;
  exp_t q0[$], q1[$];

  int ncmp = 0, nerr = 0;
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model: owner -1/0/1, beats served in the current grant, last granted master
  int owner, beats, last;
  logic [31:0] model_mem [64];
  logic [31:0] hold0, hold1;
  int wait0, wait1;
  logic obs_g0, obs_g1, obs_wr, obs_beat0, mb0, mb1;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    q0.delete(); q1.delete();
    owner = -1; beats = 0; last = 1;
    hold0 = 0; hold1 = 0; wait0 = 0; wait1 = 0;
    for (int i = 0; i < 64; i++) model_mem[i] = pat(i);
    #1;
    chk("rst_m0_gnt", m0_gnt, 0);       chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0); chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_m0_rdata", m0_rdata, 0);   chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_mem_rd", mem_rd, 0);       chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);   chk("rst_mem_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    reset = 1'b0;
  endtask

  task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    logic e_g0, e_g1, e_rd, e_wr;
    logic [31:0] e_addr, e_wd;
    int nxt, o, x;
    logic ro, rx;
    @(negedge clk);
    m0_req = r0; m0_wr = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_wr = w1; m1_addr = a1; m1_wdata = d1;
    #1;
    e_g0 = (owner == 0);
    e_g1 = (owner == 1);
    mb0 = e_g0 & r0;
    mb1 = e_g1 & r1;
    e_rd   = (mb0 & ~w0) | (mb1 & ~w1);
    e_wr   = (mb0 & w0) | (mb1 & w1);
    e_addr = mb0 ? a0 : (mb1 ? a1 : 32'h0);
    e_wd   = mb0 ? d0 : (mb1 ? d1 : 32'h0);
    chk("m0_gnt", m0_gnt, e_g0);
    chk("m1_gnt", m1_gnt, e_g1);
    chk("mem_rd", mem_rd, e_rd);
    chk("mem_wr", mem_wr, e_wr);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_wr = mem_wr; obs_beat0 = m0_gnt & m0_req;
    if (mb0 && !w0) q0.push_back('{cyc + 1, model_mem[a0[7:2]]});
    if (mb1 && !w1) q1.push_back('{cyc + 1, model_mem[a1[7:2]]});
    if (mb0 && w0) model_mem[a0[7:2]] = d0;
    if (mb1 && w1) model_mem[a1[7:2]] = d1;
    wait0 = (r0 && !m0_gnt) ? wait0 + 1 : 0;
    wait1 = (r1 && !m1_gnt) ? wait1 + 1 : 0;
    if (r0) chk("m0_wait_bound", wait0 > MB + 1, 0);
    if (r1) chk("m1_wait_bound", wait1 > MB + 1, 0);
    if (owner < 0) begin
      if (r0 && r1)  nxt = (last == 1) ? 0 : 1;
      else if (r0)   nxt = 0;
      else if (r1)   nxt = 1;
      else           nxt = -1;
    end else begin
      o  = owner;
      x  = 1 - o;
      ro = (o == 0) ? r0 : r1;
      rx = (x == 0) ? r0 : r1;
      if (!ro)                        nxt = rx ? x : -1;
      else if (rx && beats + 1 >= MB) nxt = x;
      else begin
        nxt = o;
        beats++;
      end
    end
    if (nxt != owner) begin
      beats = 0;
      if (nxt >= 0) last = nxt;
    end
    owner = nxt;
  endtask

  // Monitor: every rvalid must match the oldest outstanding read of its master, due this cycle
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!reset) begin
        if (m0_rvalid) begin
          if (q0.size() > 0 && q0[0].due == cyc) begin
            chk("m0_rdata", m0_rdata, q0[0].data);
            hold0 = q0[0].data;
            void'(q0.pop_front());
          end else chk("m0_rvalid", m0_rvalid, 0);
        end else begin
          chk("m0_rdata_hold", m0_rdata, hold0);
          if (q0.size() > 0 && q0[0].due <= cyc) begin
            chk("m0_rvalid", m0_rvalid, 1);
            void'(q0.pop_front());
          end
        end
        if (m1_rvalid) begin
          if (q1.size() > 0 && q1[0].due == cyc) begin
            chk("m1_rdata", m1_rdata, q1[0].data);
            hold1 = q1[0].data;
            void'(q1.pop_front());
          end else chk("m1_rvalid", m1_rvalid, 0);
        end else begin
          chk("m1_rdata_hold", m1_rdata, hold1);
          if (q1.size() > 0 && q1[0].due <= cyc) begin
            chk("m1_rvalid", m1_rvalid, 1);
            void'(q1.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int nb0, nwr, ng;
    logic seen1, prev_g0, pend0, pend1, r0, r1;

    // Tie after reset, then m0 burst capped at MB beats with a bubble-free handover
    do_reset();
    nb0 = 0; seen1 = 0; prev_g0 = 0;
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 32'h100 + 32'(4 * k), 0, 1, 0, 32'h80, 0);
      if (k == 1) begin
        chk("tie_m0_gnt", obs_g0, 1);
        chk("tie_m1_gnt", obs_g1, 0);
      end
      if (obs_g1 && !seen1) begin
        seen1 = 1;
        chk("handover_no_bubble", prev_g0, 1);
        chk("m0_burst_beats", nb0, MB);
      end
      if (!seen1 && obs_beat0) nb0++;
      prev_g0 = obs_g0;
    end
    chk("m1_granted", seen1, 1);

    // m1 alone writes one word, then releases
    do_reset();
    nwr = 0;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, k < 2, 1, 32'h40, 32'hDEADBEEF);
      nwr += int'(obs_wr);
    end
    chk("m1_write_beats", nwr, 1);
    chk("m1_idle_after", obs_g1, 0);

    // m0 alone keeps the grant indefinitely
    do_reset();
    ng = 0;
    for (int k = 0; k < 30; k++) begin
      step(1, 0, 32'h200 + 32'(4 * k), 0, 0, 0, 0, 0);
      if (k >= 1) ng += int'(obs_g0);
    end
    chk("m0_hold_gnt", ng, 29);

    // Reset the cycle after a read beat: pending rvalid dropped (checked inside do_reset)
    do_reset();
    step(1, 0, 32'h10, 0, 0, 0, 0, 0);
    step(1, 0, 32'h10, 0, 0, 0, 0, 0);
    do_reset();

    // Random traffic; a master keeps requesting until it has had a beat
    pend0 = 0; pend1 = 0;
    for (int n = 0; n < 10000; n++) begin
      r0 = pend0 ? 1'b1 : ($urandom_range(0, 9) < 6);
      r1 = pend1 ? 1'b1 : ($urandom_range(0, 9) < 6);
      step(r0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom,
           r1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom);
      pend0 = r0 & ~mb0;
      pend1 = r1 & ~mb1;
    end
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
